// File: rtl/dfr_output_layer.sv
// ============================================================================
// dfr_output_layer
//
// Readout layer of a delay-feedback reservoir. For each sample s it computes
// the dot product of the NUM_VIRTUAL_NODES reservoir node values stored at
// s*NUM_VIRTUAL_NODES.. with the weight vector. It then scales the sum back by
// FRAC_BITS and writes one word per sample to the output memory. The datapath
// performs one multiply-accumulate per cycle, so address issue and accumulation
// overlap.
//
// Optional feature:
//   DFR_OUTPUT_SATURATE_EN  defined   -> out_data clamps to the signed range
//                           undefined -> out_data keeps the low bits (wraps)
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, async active-low reset
//   start, num_samples         launch pulse and number of samples (taken in IDLE)
//   res_addr / res_data        reservoir history read port (1-cycle latency)
//   weight_addr / weight_data  weight memory read port (1-cycle latency)
//   out_wr_en/out_addr/out_data output memory write port
//   busy, done                 status: busy while running, done is a 1-cycle pulse
// ============================================================================
module dfr_output_layer #(
    parameter int NUM_VIRTUAL_NODES            = 100,
    parameter int RESERVOIR_DATA_WIDTH         = 32,
    parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 16,
    parameter int FRAC_BITS                    = 16
) (
    input  logic                                    S_AXI_ACLK,
    input  logic                                    S_AXI_ARESETN,
    input  logic                                    start,
    input  logic [31:0]                             num_samples,
    output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] res_addr,
    input  logic [RESERVOIR_DATA_WIDTH-1:0]         res_data,
    output logic [7:0]                              weight_addr,
    input  logic [RESERVOIR_DATA_WIDTH-1:0]         weight_data,
    output logic                                    out_wr_en,
    output logic [15:0]                             out_addr,
    output logic [RESERVOIR_DATA_WIDTH-1:0]         out_data,
    output logic                                    busy,
    output logic                                    done
);

    localparam int W      = RESERVOIR_DATA_WIDTH;
    localparam int ACC_W  = 2*W + 8;
    localparam int NODE_W = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_VIRTUAL_NODES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ACCUM, WRITE, FINISH} state_t;

    state_t                    state;
    logic [NODE_W-1:0]         node_cnt;
    logic [31:0]               sample_cnt;
    logic [31:0]               num_lat;
    logic signed [ACC_W-1:0]   acc;
    logic                      rd_vld;   // res_data/weight_data carry a fetched pair

    logic signed [2*W-1:0]     prod;
    logic signed [ACC_W-1:0]   mac_sum;
    logic signed [ACC_W-1:0]   shifted;
    logic [W-1:0]              result;
    logic                      more_samples;

    assign prod    = $signed(res_data) * $signed(weight_data);
    assign mac_sum = acc + {{8{prod[2*W-1]}}, prod};
    // Arithmetic shift drops the weight fraction, which keeps node scaling.
    assign shifted = mac_sum >>> FRAC_BITS;
    assign more_samples = ({1'b0, sample_cnt} + 33'd1) < {1'b0, num_lat};

`ifdef DFR_OUTPUT_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
    always_comb begin
        result = shifted[W-1:0];
        if (shifted > MAXV)
            result = {1'b0, {(W-1){1'b1}}};
        else if (shifted < MINV)
            result = {1'b1, {(W-1){1'b0}}};
    end
`else
    assign result = shifted[W-1:0];
`endif

    // Bits discarded by the reduction to W bits.
    logic unused_bits;
    assign unused_bits = ^{shifted[ACC_W-1:W], mac_sum[FRAC_BITS-1:0]};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state       <= IDLE;
            node_cnt    <= '0;
            sample_cnt  <= '0;
            num_lat     <= '0;
            acc         <= '0;
            rd_vld      <= 1'b0;
            res_addr    <= '0;
            weight_addr <= '0;
            out_wr_en   <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_vld    <= (state == FETCH);
            out_wr_en <= 1'b0;
            done      <= 1'b0;
            if (rd_vld)
                acc <= mac_sum;

            case (state)
                IDLE: begin
                    if (start) begin
                        num_lat    <= num_samples;
                        sample_cnt <= '0;
                        if (num_samples != 32'd0) begin
                            state       <= FETCH;
                            busy        <= 1'b1;
                            acc         <= '0;
                            node_cnt    <= '0;
                            res_addr    <= '0;
                            weight_addr <= '0;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (node_cnt == LAST_NODE) begin
                        state <= ACCUM;
                    end else begin
                        node_cnt    <= node_cnt + 1'b1;
                        res_addr    <= res_addr + 1'b1;
                        weight_addr <= weight_addr + 8'd1;
                    end
                end
                ACCUM: begin
                    // The last product is still in flight, so the output word
                    // is formed from the final sum rather than from acc.
                    state     <= WRITE;
                    out_wr_en <= 1'b1;
                    out_addr  <= sample_cnt[15:0];
                    out_data  <= result;
                end
                WRITE: begin
                    if (more_samples) begin
                        state       <= FETCH;
                        sample_cnt  <= sample_cnt + 32'd1;
                        acc         <= '0;
                        node_cnt    <= '0;
                        // res_addr still holds the last node of this sample,
                        // so the next base follows directly and wraps naturally.
                        res_addr    <= res_addr + 1'b1;
                        weight_addr <= '0;
                    end else begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dfr_output_layer.sv
module tb_dfr_output_layer;

    localparam int N  = 100;
    localparam int W  = 32;
    localparam int AW = 16;
    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   num_samples = '0;
    logic [AW-1:0] res_addr;
    logic [W-1:0]  res_data;
    logic [7:0]    weight_addr;
    logic [W-1:0]  weight_data;
    logic          out_wr_en;
    logic [15:0]   out_addr;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          done;

    dfr_output_layer #(
        .NUM_VIRTUAL_NODES(N), .RESERVOIR_DATA_WIDTH(W),
        .RESERVOIR_HISTORY_ADDR_WIDTH(AW), .FRAC_BITS(FB)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start),
        .num_samples(num_samples), .res_addr(res_addr), .res_data(res_data),
        .weight_addr(weight_addr), .weight_data(weight_data),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] res_mem [0:65535];
    logic [W-1:0] weight_mem [0:255];

    // Synchronous read memories: data one cycle after the address.
    always @(posedge clk) begin
        res_data    <= res_mem[res_addr];
        weight_data <= weight_mem[weight_addr];
    end

    int vectors = 0;
    int errors  = 0;
    int wr_seen = 0;
    logic [W-1:0]  wlog [0:15];
    logic [W-1:0]  exp_q [$];
    logic [15:0]   exp_a [$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Expected output word of sample s: dot product, shift, reduce.
    function automatic logic [W-1:0] model(input int s);
        logic signed [71:0] acc;
        logic signed [71:0] sh;
        acc = 0;
        for (int n = 0; n < N; n++) begin
            logic signed [31:0] r;
            logic signed [31:0] w;
            r = res_mem[(s*N + n) % 65536];
            w = weight_mem[n];
            acc = acc + r * w;
        end
        sh = acc >>> FB;
`ifdef DFR_OUTPUT_SATURATE_EN
        if (sh > 72'sd2147483647) return 32'h7FFF_FFFF;
        if (sh < -72'sd2147483648) return 32'h8000_0000;
`endif
        return sh[31:0];
    endfunction

    // Every write is checked against the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && out_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("write_expected", 64'(out_addr), 64'hFFFF_FFFF);
            end else begin
                logic [W-1:0] ed;
                logic [15:0]  ea;
                ed = exp_q.pop_front();
                ea = exp_a.pop_front();
                chk("write_addr", 64'(out_addr), 64'(ea));
                chk("write_data", 64'(out_data), 64'(ed));
            end
            if (wr_seen < 16) wlog[wr_seen] = out_data;
            wr_seen++;
        end
    end

    task automatic expect_samples(input int ns);
        for (int s = 0; s < ns; s++) begin
            exp_q.push_back(model(s));
            exp_a.push_back(16'(s));
        end
    endtask

    // Launch a run, time done, optionally fire a stray start at cycle ign_at.
    task automatic run(input int ns, input int ign_at);
        int lat;
        expect_samples(ns);
        wr_seen = 0;
        @(negedge clk);
        start = 1'b1;
        num_samples = 32'(ns);
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (lat == 1) chk("busy_after_start", 64'(busy), 64'(ns > 0));
            if (done) break;
            if (lat == ign_at) begin
                start = 1'b1;
                num_samples = 32'd7;
            end
        end
        chk("done_latency", 64'(lat), 64'(ns*(N+2) + 1));
        chk("busy_at_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("done_pulse_width", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("write_count", 64'(wr_seen), 64'(ns));
        chk("expect_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fill_varied();
        for (int s = 0; s < 3; s++)
            for (int n = 0; n < N; n++)
                res_mem[s*N + n] = 32'((n - 50) * 65536 + s * 1000 + 7);
        for (int n = 0; n < N; n++)
            weight_mem[n] = 32'(n * 37 - 1000);
    endtask

    task automatic check_zero_outputs();
        chk("reset_ctrl", 64'({busy, done, out_wr_en}), 64'd0);
        chk("reset_addr", 64'({res_addr, weight_addr, out_addr}), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) res_mem[i] = '0;
        for (int i = 0; i < 256; i++) weight_mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unity nodes and weights: 100 * 1.0
        for (int n = 0; n < N; n++) begin
            res_mem[n] = 32'd65536;
            weight_mem[n] = 32'd65536;
        end
        run(1, 0);
        chk("unity_value", 64'(wlog[0]), 64'd6553600);

        // Integer nodes s+1 over three samples
        for (int s = 0; s < 3; s++)
            for (int n = 0; n < N; n++)
                res_mem[s*N + n] = 32'(s + 1);
        run(3, 0);
        chk("int_s0", 64'(wlog[0]), 64'd100);
        chk("int_s1", 64'(wlog[1]), 64'd200);
        chk("int_s2", 64'(wlog[2]), 64'd300);

        // Zero samples
        run(0, 0);

        // Overflowing sum
        for (int n = 0; n < N; n++) begin
            res_mem[n] = 32'h7FFF_FFFF;
            weight_mem[n] = 32'h7FFF_FFFF;
        end
        run(1, 0);
`ifdef DFR_OUTPUT_SATURATE_EN
        chk("ovf_value", 64'(wlog[0]), 64'h7FFF_FFFF);
`else
        chk("ovf_value", 64'(wlog[0]), 64'hFF9C_0000);
`endif

        // Signed mixed data with a stray start while busy
        fill_varied();
        run(3, 10);

        // Reset at node 50 of sample 1, then a fresh run
        expect_samples(1);
        wr_seen = 0;
        @(negedge clk);
        start = 1'b1;
        num_samples = 32'd3;
        @(negedge clk);
        start = 1'b0;
        begin
            int t;
            t = 0;
            while (res_addr != 16'(N + 50) && t < 1000) begin
                @(negedge clk);
                t++;
            end
            chk("reach_node50", 64'(res_addr), 64'(N + 50));
        end
        rst_n = 1'b0;
        #1;
        check_zero_outputs();
        chk("abort_writes", 64'(wr_seen), 64'd1);
        chk("abort_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        exp_a.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("no_write_after_reset", 64'(wr_seen), 64'd1);
        chk("idle_after_reset", 64'(busy), 64'd0);
        run(3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
